// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: execute-stage arithmetic unit.
// Single-cycle integer ALU ops plus iterative radix-2 multiply/divide
// (one bit per cycle). Valid/ready in, registered result out, flush abort.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN),
  parameter int CW   = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      alu_ctrl,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            out_valid,
  output logic            lt_flag,
  output logic            ltu_flag,
  output logic            zero_flag
);

  localparam logic [4:0] OP_ADD    = 5'h00;
  localparam logic [4:0] OP_SUB    = 5'h01;
  localparam logic [4:0] OP_AND    = 5'h02;
  localparam logic [4:0] OP_OR     = 5'h03;
  localparam logic [4:0] OP_XOR    = 5'h04;
  localparam logic [4:0] OP_SLL    = 5'h05;
  localparam logic [4:0] OP_SRL    = 5'h06;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_SLT    = 5'h08;
  localparam logic [4:0] OP_SLTU   = 5'h09;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q, acc_q, mq_q, opb_q;
  logic [4:0]      op_q;
  logic            neg_q, out_valid_q, lt_q, ltu_q;

  logic            accept_s, lt_s, ltu_s, s1_s, s2_s;
  logic            is_md_s, is_mul_s, early_s, md_iter_s;
  logic [SHW-1:0]  shamt_s;
  logic [XLEN-1:0] alu_res_s, early_res_s, one_res_s, abs1_s, abs2_s;
  logic [XLEN-1:0] init_mq_s, init_opb_s, fin_res_s, acc_d, mq_d;
  logic            init_neg_s;
  logic [XLEN:0]   add_s, shl_s, diff_s;
  logic [XLEN-1:0] mul_acc_s, mul_mq_s, div_acc_s, div_mq_s;
  logic [2*XLEN-1:0] prod_s, prod_fix_s;

  // Flush in the accept cycle wins over the request.
  assign accept_s  = in_valid & in_ready & ~flush;
  assign in_ready  = (state_q == S_IDLE);
  assign result    = result_q;
  // A flush in the cycle the pulse is visible kills it (pending or DONE result).
  assign out_valid = out_valid_q & ~flush;
  assign lt_flag   = lt_q;
  assign ltu_flag  = ltu_q;
  assign zero_flag = (result_q == '0);

  assign lt_s     = $signed(op1) < $signed(op2);
  assign ltu_s    = op1 < op2;
  assign s1_s     = op1[XLEN-1];
  assign s2_s     = op2[XLEN-1];
  assign abs1_s   = s1_s ? -op1 : op1;
  assign abs2_s   = s2_s ? -op2 : op2;
  assign shamt_s  = op2[SHW-1:0];
  assign is_md_s  = (alu_ctrl[4:3] == 2'b10);
  assign is_mul_s = is_md_s & ~alu_ctrl[2];

  // Single-cycle ALU result; unknown encodings yield zero.
  always_comb begin
    alu_res_s = '0;
    case (alu_ctrl)
      OP_ADD:  alu_res_s = op1 + op2;
      OP_SUB:  alu_res_s = op1 - op2;
      OP_AND:  alu_res_s = op1 & op2;
      OP_OR:   alu_res_s = op1 | op2;
      OP_XOR:  alu_res_s = op1 ^ op2;
      OP_SLL:  alu_res_s = op1 << shamt_s;
      OP_SRL:  alu_res_s = op1 >> shamt_s;
      OP_SRA:  alu_res_s = $signed(op1) >>> shamt_s;
      OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, ltu_s};
      default: alu_res_s = '0;
    endcase
  end

  // Muldiv operand setup (magnitudes + final sign) and early-out detection.
  always_comb begin
    early_s     = 1'b0;
    early_res_s = '0;
    init_mq_s   = op2;
    init_opb_s  = op1;
    init_neg_s  = 1'b0;
    case (alu_ctrl)
      OP_MUL, OP_MULHU: begin
        early_s    = (op1 == '0) || (op2 == '0);
        init_mq_s  = op2;
        init_opb_s = op1;
      end
      OP_MULH: begin
        early_s    = (op1 == '0) || (op2 == '0);
        init_mq_s  = abs2_s;
        init_opb_s = abs1_s;
        init_neg_s = s1_s ^ s2_s;
      end
      OP_MULHSU: begin
        early_s    = (op1 == '0) || (op2 == '0);
        init_mq_s  = op2;
        init_opb_s = abs1_s;
        init_neg_s = s1_s;
      end
      OP_DIV, OP_REM: begin
        init_mq_s  = abs1_s;
        init_opb_s = abs2_s;
        init_neg_s = (alu_ctrl == OP_DIV) ? (s1_s ^ s2_s) : s1_s;
        if (op2 == '0) begin
          early_s     = 1'b1;
          early_res_s = (alu_ctrl == OP_DIV) ? '1 : op1;
        end else if ((op1 == MOST_NEG) && (op2 == '1)) begin
          early_s     = 1'b1;
          early_res_s = (alu_ctrl == OP_DIV) ? op1 : '0;
        end else begin
          early_s     = 1'b0;
        end
      end
      OP_DIVU, OP_REMU: begin
        init_mq_s  = op1;
        init_opb_s = op2;
        if (op2 == '0) begin
          early_s     = 1'b1;
          early_res_s = (alu_ctrl == OP_DIVU) ? '1 : op1;
        end else begin
          early_s     = 1'b0;
        end
      end
      default: early_s = 1'b0;
    endcase
  end

  assign md_iter_s = is_md_s & ~early_s;
  assign one_res_s = is_md_s ? early_res_s : alu_res_s;

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    add_s     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_acc_s = add_s[XLEN:1];
    mul_mq_s  = {add_s[0], mq_q[XLEN-1:1]};
    shl_s     = {acc_q, mq_q[XLEN-1]};
    diff_s    = shl_s - {1'b0, opb_q};
    div_acc_s = diff_s[XLEN] ? shl_s[XLEN-1:0] : diff_s[XLEN-1:0];
    div_mq_s  = {mq_q[XLEN-2:0], ~diff_s[XLEN]};
    if (state_q == S_MUL) begin
      acc_d = mul_acc_s;
      mq_d  = mul_mq_s;
    end else begin
      acc_d = div_acc_s;
      mq_d  = div_mq_s;
    end
    prod_s     = {mul_acc_s, mul_mq_s};
    prod_fix_s = neg_q ? -prod_s : prod_s;
  end

  // Final-iteration result selection with sign fix-up.
  always_comb begin
    fin_res_s = '0;
    case (op_q)
      OP_MUL:                       fin_res_s = prod_fix_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res_s = prod_fix_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res_s = neg_q ? -div_mq_s : div_mq_s;
      OP_REM, OP_REMU:              fin_res_s = neg_q ? -div_acc_s : div_acc_s;
      default:                      fin_res_s = '0;
    endcase
  end

  // Control FSM and all datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      mq_q        <= '0;
      opb_q       <= '0;
      op_q        <= 5'h00;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_valid_q <= 1'b0;
          if (accept_s) begin
            op_q  <= alu_ctrl;
            lt_q  <= lt_s;
            ltu_q <= ltu_s;
            if (md_iter_s) begin
              state_q <= is_mul_s ? S_MUL : S_DIV;
              cnt_q   <= CW'(XLEN);
              acc_q   <= '0;
              mq_q    <= init_mq_s;
              opb_q   <= init_opb_s;
              neg_q   <= init_neg_s;
            end else begin
              result_q    <= one_res_s;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            acc_q <= acc_d;
            mq_q  <= mq_d;
            if (cnt_q == CW'(1)) begin
              state_q     <= S_DONE;
              result_q    <= fin_res_s;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: vector table plus hand sequences,
// with a queue scoreboard popped whenever out_valid is seen.
`timescale 1ns/1ps
module tb_alu_mdu_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] op1 = '0;
  logic [XLEN-1:0] op2 = '0;
  logic [4:0]      alu_ctrl = 5'h00;
  logic            flush = 1'b0;
  logic [XLEN-1:0] result;
  logic            out_valid, lt_flag, ltu_flag, zero_flag;

  always #5 clk = ~clk;

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_ctrl(alu_ctrl), .flush(flush),
    .result(result), .out_valid(out_valid), .lt_flag(lt_flag),
    .ltu_flag(ltu_flag), .zero_flag(zero_flag)
  );

  typedef struct {
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          acc_cyc;
    int          lat;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check({e.name, " result"}, result, e.exp);
        check({e.name, " latency"}, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        check({e.name, " zero_flag"}, {31'b0, zero_flag}, (e.exp == 32'h0) ? 32'd1 : 32'd0);
      end
    end
  end

  // Present one op for one cycle; call and return at posedge+1.
  task automatic issue(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push, input string name);
    sb_t e;
    op1 = a; op2 = b; alu_ctrl = ctrl; in_valid = 1'b1;
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, " lt_flag"}, {31'b0, lt_flag}, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
    check({name, " ltu_flag"}, {31'b0, ltu_flag}, (a < b) ? 32'd1 : 32'd0);
    if (push) begin
      e.exp = exp; e.acc_cyc = cyc; e.lat = lat; e.name = name;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: got %0d outstanding results expected 0 after %0d cycles", name, sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  // Muldiv op with in_ready watched low for all XLEN+1 busy cycles.
  task automatic busy_op(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    int lows = 0;
    issue(ctrl, a, b, exp, XLEN + 1, 1'b1, name);
    for (int k = 0; k < XLEN + 1; k++) begin
      @(negedge clk);
      if (in_ready === 1'b0) lows++;
      @(posedge clk); #1;
    end
    check({name, " busy cycles"}, 32'(lows), 32'(XLEN + 1));
    @(negedge clk);
    check({name, " in_ready after"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drain(2, name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
    vecs.push_back('{5'h01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
    vecs.push_back('{5'h02, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
    vecs.push_back('{5'h03, 32'h12340000, 32'h00005678, 32'h12345678, 1});
    vecs.push_back('{5'h04, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1});
    vecs.push_back('{5'h05, 32'h00000001, 32'h00000021, 32'h00000002, 1});
    vecs.push_back('{5'h06, 32'h80000000, 32'h00000004, 32'h08000000, 1});
    vecs.push_back('{5'h07, 32'h80000000, 32'h00000024, 32'hF8000000, 1});
    vecs.push_back('{5'h08, 32'hFFFFFFFB, 32'h00000003, 32'h00000001, 1});
    vecs.push_back('{5'h09, 32'hFFFFFFFB, 32'h00000003, 32'h00000000, 1});
    vecs.push_back('{5'h0A, 32'h00000001, 32'h00000002, 32'h00000000, 1});
    vecs.push_back('{5'h1F, 32'h00000005, 32'h00000006, 32'h00000000, 1});
    vecs.push_back('{5'h10, 32'h00000007, 32'h00000006, 32'h0000002A, 33});
    vecs.push_back('{5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
    vecs.push_back('{5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
    vecs.push_back('{5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 33});
    vecs.push_back('{5'h13, 32'h80000000, 32'h00000004, 32'h00000002, 33});
    vecs.push_back('{5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33});
    vecs.push_back('{5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33});
    vecs.push_back('{5'h14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33});
    vecs.push_back('{5'h16, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33});
    vecs.push_back('{5'h17, 32'h00000064, 32'h00000007, 32'h00000002, 33});
    vecs.push_back('{5'h15, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 33});
    vecs.push_back('{5'h15, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{5'h17, 32'h00000007, 32'h00000000, 32'h00000007, 1});
    vecs.push_back('{5'h14, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1});
    vecs.push_back('{5'h16, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFD, 1});
    vecs.push_back('{5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    vecs.push_back('{5'h10, 32'h00000000, 32'h00012345, 32'h00000000, 1});
    vecs.push_back('{5'h13, 32'h00000005, 32'h00000000, 32'h00000000, 1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result", result, 32'h0);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset lt_flag", {31'b0, lt_flag}, 32'd0);
    check("reset ltu_flag", {31'b0, ltu_flag}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1, $sformatf("vec%0d", i));
      drain(XLEN + 8, $sformatf("vec%0d", i));
    end

    // Multiply-high with busy window
    busy_op(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
    busy_op(5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");

    // Flush at iteration 10 of DIVU 100/7
    issue(5'h00, 32'd3, 32'd4, 32'd7, 1, 1'b1, "add_pre");
    drain(5, "add_pre");
    issue(5'h15, 32'd100, 32'd7, 32'd0, XLEN + 1, 1'b0, "divu_flushed");
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush in_ready", {31'b0, in_ready}, 32'd1);
    check("flush result kept", result, 32'd7);
    repeat (40) @(posedge clk);
    #1;
    check("flush result still kept", result, 32'd7);
    issue(5'h15, 32'd100, 32'd7, 32'd14, XLEN + 1, 1'b1, "divu_after_flush");
    drain(XLEN + 8, "divu_after_flush");

    // Flush wins over in_valid in IDLE
    op1 = 32'd1; op2 = 32'd1; alu_ctrl = 5'h00; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_idle result", result, 32'd14);
    @(posedge clk); #1;

    // Reset during a multiply
    issue(5'h10, 32'd7, 32'd6, 32'd0, XLEN + 1, 1'b0, "mul_reset");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midreset result", result, 32'h0);
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Back-to-back single-cycle ops
    issue(5'h00, 32'd1, 32'd2, 32'd3, 1, 1'b1, "b2b0");
    issue(5'h00, 32'd10, 32'd20, 32'd30, 1, 1'b1, "b2b1");
    issue(5'h01, 32'd0, 32'd1, 32'hFFFFFFFF, 1, 1'b1, "b2b2");
    drain(5, "b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Parametrised next-generation execute-stage arithmetic unit.
- Single-cycle RV32I integer ops are extended with iterative RV M-extension multiply/divide (radix-2, one bit per cycle).
- Accepts one operation at a time through a valid/ready handshake and returns a registered result with a one-cycle out_valid pulse.
- The execute stage stalls on in_ready=0 and uses flush to kill an in-flight op on redirect.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount bits taken from op2 (derived; do not override).
- CW, $clog2(XLEN+1), iteration counter width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op1  in  XLEN  operand A / multiplicand / dividend.
- op2  in  XLEN  operand B / multiplier / divisor.
- alu_ctrl  in  5  opcode (encodings under Behaviour).
- flush  in  1  abort in-flight op.
- result  out  XLEN  registered result; held until the next out_valid.
- out_valid  out  1  one-cycle pulse; result valid this cycle.
- lt_flag  out  1  registered: $signed(op1) < $signed(op2) of the accepted op.
- ltu_flag  out  1  registered: unsigned op1 < op2 of the accepted op.
- zero_flag  out  1  combinational: result == 0.

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE; result=0; out_valid=0; lt_flag=0; ltu_flag=0; counter=0; internal accumulators=0. Reset overrides flush and in_valid. Reset mid-iteration discards the op with no out_valid.
- Accept: occurs on an edge where in_valid && in_ready. Operands and opcode are latched; lt/ltu flags are computed from the raw operands and registered at the accept edge.
- Encodings 0x00-0x09, single-cycle, registered:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR: wrap modulo 2^XLEN.
  - 0x05 SLL, 0x06 SRL, 0x07 SRA: shift by op2[SHW-1:0].
  - 0x08 SLT, 0x09 SLTU: result = zero-extended 1/0.
  - Result is written at the accept edge; out_valid=1 in the following cycle.
  - Latency 1; unit stays in IDLE, so back-to-back accepts are allowed every cycle.
- Encodings 0x10-0x17, multi-cycle: 0x10 MUL (low half), 0x11 MULH (s×s high), 0x12 MULHSU (s×u high), 0x13 MULHU (u×u high), 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - Signed ops convert operands to magnitudes at accept; the sign fix-up is applied in the final iteration.
- Any other encoding: result=0, latency 1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL or DIV on accept of a muldiv opcode; counter loaded with XLEN.
  - MUL/DIV: one shift-add or shift-subtract step per cycle; counter decrements each cycle.
  - Counter reaching 0 -> DONE, with result written on the same edge.
  - DONE: out_valid=1 for one cycle; in_ready=0 -> IDLE.
  - Muldiv latency = XLEN+1 cycles from the accept edge to the out_valid cycle. Next accept is possible in the cycle after the DONE cycle.
- Early-out cases (latency 1, no iteration, unit stays in IDLE):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = op1.
  - Signed overflow (op1 = most negative value, op2 = -1): DIV = op1; REM = 0.
  - Multiply with either operand 0: result = 0.
- flush:
  - In MUL, DIV or DONE: next state IDLE; out_valid suppressed; result retains its prior value.
  - In IDLE: blocks the accept on that same edge and clears a pending single-cycle out_valid.
  - flush and in_valid in the same cycle: flush wins.
- out_valid is never high on two consecutive cycles for a single op. result is never modified except at a result-write edge or reset.

Test Plan:
- Reset/ADD: hold rst=0 for 2 cycles -> result=0, out_valid=0, in_ready=1. Then ADD 0xFFFFFFFF+1 -> result 0x00000000, zero_flag=1, out_valid at T+1.
- Shift/SRA: op1=0x80000000, op2=0x24 -> SRA result 0xF8000000 (shift 4). SLT -5,3 -> 1 with lt_flag=1, ltu_flag=0.
- MULH/MULHU: 0xFFFFFFFF × 0xFFFFFFFF -> MULH 0x00000000 and MULHU 0xFFFFFFFE. Each has out_valid exactly at cycle T+33 and in_ready=0 from T+1 through T+33.
- DIV/REM signed: -7 / 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU 7/0 -> 0xFFFFFFFF at T+1. DIV 0x80000000 / -1 -> 0x80000000 at T+1.
- Flush: flush asserted at iteration 10 of DIVU 100/7 -> no out_valid, result unchanged, in_ready=1 next cycle. Then DIVU 100/7 completes with result 14.
- Reset mid-op: rst=0 during MUL -> IDLE, result=0, no out_valid. Back-to-back ADDs on consecutive cycles -> consecutive out_valid pulses with correct results.
